mult_control: RTL and testbench

Sequencing controller for the signed 8×8 shift-add multiplier datapath.
- Owns the iteration counter and the state machine.
- Drives the load, clear, shift and add/subtract controls of the accumulator register (A plus sign bit X) and the multiplier register (B).
- Sits directly upstream of both 8-bit shift registers. It consumes B's shift-out bit (M) and produces their Load/Shift_En/Reset controls.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/mult_control_if.sv | 25 ++
 rtl/mult_iter_cnt.sv | 39 +++
 rtl/mult_control.sv | 124 ++++++++++++
 tb/tb_mult_control.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the signed shift-add multiplier controller.
package mult_pkg;

  // Operand width, also the number of add/shift iterations per multiply.
  localparam int MULT_WIDTH = 8;

  // Counter width needed to hold 0..w (the counter reaches w after the last shift).
  function automatic int mult_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int MULT_CNT_W = mult_cnt_w(MULT_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ADD,
    SHIFT,
    HOLD
  } mult_state_t;

endpackage

// File: rtl/mult_control_if.sv
// Control/status bundle between the multiplier sequencer and its datapath.
// master: the sequencer (drives register controls, reads requests and M).
// slave:  the datapath/environment side.
interface mult_control_if;
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Clr_XA;
  logic Ld_B;
  logic Ld_XA;
  logic Fn;
  logic Shift_En;
  logic Busy;
  logic Done;

  modport master (
    input  Run, ClearA_LoadB, M,
    output Clr_XA, Ld_B, Ld_XA, Fn, Shift_En, Busy, Done
  );

  modport slave (
    output Run, ClearA_LoadB, M,
    input  Clr_XA, Ld_B, Ld_XA, Fn, Shift_En, Busy, Done
  );
endinterface

// File: rtl/mult_iter_cnt.sv
// Iteration counter: synchronous clear, increment, and terminal flag on the
// last iteration (cnt == WIDTH-1).
module mult_iter_cnt
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic inc,
  output logic last
);
  localparam int CW = mult_cnt_w(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;

  // clear has priority over increment; otherwise hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // counter register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_control.sv
// Sequencer for the signed WIDTHxWIDTH shift-add multiplier.
// Optional build macro: MULT_SKIP_ADD_EN -- an ADD cycle with M=0 performs the
// shift itself, removing the separate SHIFT cycle for zero multiplier bits.
//
//   state | meaning
//   IDLE  | waiting; ClearA_LoadB clears X/A and loads B
//   CLEAR | clear X/A, reset iteration counter
//   ADD   | conditionally load X:A from adder (subtract on last iteration)
//   SHIFT | shift X:A:B right, advance iteration counter
//   HOLD  | product valid; wait for Run to drop
module mult_control
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic           Clk,
  input  logic           Reset,
  mult_control_if.master bus
);

  mult_state_t state_q, state_d;

  logic cnt_clr;
  logic cnt_inc;
  logic cnt_last;

  logic clr_xa;
  logic ld_b;
  logic ld_xa;
  logic fn;
  logic shift_en;
  logic busy;
  logic done;

  mult_iter_cnt #(.WIDTH(WIDTH)) u_iter_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .last  (cnt_last)
  );

  // state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and control decode; everything is forced low while Reset is
  // high so an abort emits no stray pulse even if ClearA_LoadB is up
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    clr_xa   = 1'b0;
    ld_b     = 1'b0;
    ld_xa    = 1'b0;
    fn       = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    if (!Reset) begin
      case (state_q)
        IDLE: begin
          if (bus.Run) begin
            state_d = CLEAR;
          end else if (bus.ClearA_LoadB) begin
            clr_xa = 1'b1;
            ld_b   = 1'b1;
          end
        end
        CLEAR: begin
          busy    = 1'b1;
          clr_xa  = 1'b1;
          cnt_clr = 1'b1;
          state_d = ADD;
        end
        ADD: begin
          busy = 1'b1;
`ifdef MULT_SKIP_ADD_EN
          if (bus.M) begin
            ld_xa   = 1'b1;
            fn      = cnt_last;
            state_d = SHIFT;
          end else begin
            shift_en = 1'b1;
            cnt_inc  = 1'b1;
            state_d  = cnt_last ? HOLD : ADD;
          end
`else
          ld_xa   = bus.M;
          fn      = bus.M & cnt_last;
          state_d = SHIFT;
`endif
        end
        SHIFT: begin
          busy     = 1'b1;
          shift_en = 1'b1;
          cnt_inc  = 1'b1;
          state_d  = cnt_last ? HOLD : ADD;
        end
        HOLD: begin
          done    = 1'b1;
          state_d = bus.Run ? HOLD : IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.Clr_XA   = clr_xa;
  assign bus.Ld_B     = ld_b;
  assign bus.Ld_XA    = ld_xa;
  assign bus.Fn       = fn;
  assign bus.Shift_En = shift_en;
  assign bus.Busy     = busy;
  assign bus.Done     = done;

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: drives a behavioural X:A:B datapath from the DUT
// controls and compares product, pulse counts and latency to arithmetic
// expectations. Honours MULT_SKIP_ADD_EN for the latency expectation.
module tb_mult_control;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [7:0] sw = 8'h00;

  logic       X_r = 1'b0;
  logic [7:0] A_r = 8'h00;
  logic [7:0] B_r = 8'h00;

  int n_chk = 0;
  int n_err = 0;

  mult_control_if bus ();

  mult_control dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  always #5 Clk = ~Clk;

  assign bus.M = B_r[0];

  // behavioural datapath: 9-bit signed adder into X:A, arithmetic right shift of X:A:B
  always @(posedge Clk) begin
    if (bus.Clr_XA) begin
      X_r <= 1'b0;
      A_r <= 8'h00;
    end else if (bus.Ld_XA) begin
      if (bus.Fn) {X_r, A_r} <= {A_r[7], A_r} - {sw[7], sw};
      else        {X_r, A_r} <= {A_r[7], A_r} + {sw[7], sw};
    end else if (bus.Shift_En) begin
      A_r <= {X_r, A_r[7:1]};
    end
    if (bus.Ld_B)          B_r <= sw;
    else if (bus.Shift_En) B_r <= {A_r[0], B_r[7:1]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.Clr_XA, bus.Ld_B, bus.Ld_XA, bus.Fn, bus.Shift_En, bus.Busy, bus.Done};
  endfunction

  // load B with b, then multiply by s; optionally keep Run high hold_n cycles in HOLD
  task automatic do_mult(input logic [7:0] s, input logic [7:0] b, input int hold_n);
    int busy_n, sh_n, ld_n, fn_n, fnld_n, ldb_n, clr_n, done_cyc, exp_busy, hold_bad;
    int p;
    busy_n = 0; sh_n = 0; ld_n = 0; fn_n = 0; fnld_n = 0;
    ldb_n = 0; clr_n = 0; done_cyc = 0; hold_bad = 0;
`ifdef MULT_SKIP_ADD_EN
    exp_busy = 1 + 8 + $countones(b);
`else
    exp_busy = 17;
`endif
    @(negedge Clk);
    sw = b;
    bus.Run = 1'b0;
    bus.ClearA_LoadB = 1'b1;
    #1 chk("load_ctrl", outs(), 7'b1100000);
    @(negedge Clk);
    bus.ClearA_LoadB = 1'b0;
    sw = s;
    chk("b_loaded", {X_r, A_r, B_r}, {9'h000, b});
    bus.Run = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge Clk);
      bus.ClearA_LoadB = 1'($urandom_range(0, 1));
      #1;
      if (bus.Busy)             busy_n++;
      if (bus.Shift_En)         sh_n++;
      if (bus.Ld_XA)            ld_n++;
      if (bus.Fn)               fn_n++;
      if (bus.Fn && bus.Ld_XA)  fnld_n++;
      if (bus.Ld_B)             ldb_n++;
      if (bus.Clr_XA)           clr_n++;
      if (bus.Done) begin
        done_cyc = cyc;
        break;
      end
    end
    bus.ClearA_LoadB = 1'b0;
    chk("done_cycle", done_cyc, exp_busy + 1);
    chk("busy_cycles", busy_n, exp_busy);
    chk("ld_xa_pulses", ld_n, $countones(b));
    chk("fn_pulses", fn_n, {31'd0, b[7]});
    chk("fn_with_ld", fnld_n, {31'd0, b[7]});
    chk("ld_b_ignored", ldb_n, 0);
    chk("clr_pulses", clr_n, 1);
    for (int i = 0; i < hold_n; i++) begin
      @(negedge Clk);
      #1;
      if (bus.Shift_En) sh_n++;
      if (!bus.Done || bus.Busy || bus.Ld_XA || bus.Shift_En) hold_bad++;
    end
    chk("hold_stable", hold_bad, 0);
    chk("shift_pulses", sh_n, 8);
    p = $signed(s) * $signed(b);
    chk("product", {A_r, B_r}, p[15:0]);
    chk("x_sign", X_r, p[15]);
    @(negedge Clk);
    bus.Run = 1'b0;
    @(negedge Clk);
    #1 chk("idle_after_hold", outs(), 7'b0000000);
  endtask

  initial begin
    bus.Run = 1'b0;
    bus.ClearA_LoadB = 1'b1;
    repeat (2) @(negedge Clk);
    #1 chk("reset_outs", outs(), 7'b0000000);
    bus.ClearA_LoadB = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    #1 chk("idle_outs", outs(), 7'b0000000);

    do_mult(8'h3B, 8'h07, 0);
    do_mult(8'h07, 8'hF9, 0);
    do_mult(8'h12, 8'h34, 10);
    do_mult(8'hAB, 8'h01, 0);
    do_mult(8'h55, 8'h00, 0);
    do_mult(8'h80, 8'h80, 1);
    do_mult(8'h7F, 8'hFF, 0);

    // Run and ClearA_LoadB together in IDLE: Run wins, no Ld_B
    @(negedge Clk);
    bus.Run = 1'b1;
    bus.ClearA_LoadB = 1'b1;
    #1 chk("run_prio_idle", outs(), 7'b0000000);
    @(negedge Clk);
    #1 chk("run_prio_clear", outs(), 7'b1000010);
    bus.Run = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    repeat (20) @(negedge Clk);
    #1 chk("run_prio_back_idle", outs(), 7'b0000000);

    // asynchronous reset in the middle of ADD
    @(negedge Clk);
    bus.Run = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    #1 chk("in_add_busy", {bus.Busy, bus.Shift_En, bus.Clr_XA}, 3'b100);
    #1 Reset = 1'b1;
    #1 chk("mid_add_reset", outs(), 7'b0000000);
    bus.Run = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    #1 chk("after_reset_idle", outs(), 7'b0000000);
    do_mult(8'hC3, 8'h5A, 0);

    for (int k = 0; k < 16; k++) begin
      do_mult(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
